// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: step width, T-states and opcodes.
package control_sequencer_pkg;

    localparam int STEP_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Mod-5 T-state counter: advances T0..T4 when enabled, holds otherwise,
// cleared asynchronously to T0.
module step_counter
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [STEP_W-1:0] step
);

    tstate_e state_q;
    tstate_e state_d;

    // State register with asynchronous clear back to T0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: wrap after T4, hold whenever not enabled.
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                T0:      state_d = T1;
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                default: state_d = T0;
            endcase
        end
    end

    assign step = state_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode-style control sequencer: owns the instruction register and halt
// flag, and decodes (step, IR, halted) into active-low bus/register controls.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] ir_bus_out,
    output logic              ir_bus_enable_n,
    output logic              reg_a_load_n,
    output logic              reg_a_bus_enable_n,
    output logic              reg_b_load_n,
    output logic              alu_enable_n,
    output logic              alu_subtract,
    output logic              ram_bus_enable_n,
    output logic              ram_write_enable_n,
    output logic              ram_load_mar_reg_n,
    output logic              program_counter_enable,
    output logic              jump_n,
    output logic              program_counter_bus_enable_n,
    output logic              out_load_n,
    output logic              halted,
    output logic [STEP_W-1:0] step,
    output logic [3:0]        opcode
);

    logic [DATA_W-1:0] ir_q;
    logic              halted_q;
    logic [STEP_W-1:0] step_q;
    logic              advance;

    // Once halted the counter freezes; it then sits at T3 because the halt
    // flag and the T2->T3 transition share the same edge.
    assign advance = run & ~halted_q;

    step_counter u_step_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (advance),
        .step   (step_q)
    );

    // Instruction register: captures the fetched word on the edge ending T1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
        end else if (advance && (step_q == T1)) begin
            ir_q <= bus_in;
        end
    end

    // Halt flag: set on the edge ending T2 of HLT, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (advance && (step_q == T2) && (ir_q[7:4] == OP_HLT)) begin
            halted_q <= 1'b1;
        end
    end

    // Control decode; reset is included so the T0 decode cannot leak out
    // while reset is still asserted.
    always_comb begin
        ir_bus_enable_n              = 1'b1;
        reg_a_load_n                 = 1'b1;
        reg_a_bus_enable_n           = 1'b1;
        reg_b_load_n                 = 1'b1;
        alu_enable_n                 = 1'b1;
        alu_subtract                 = 1'b0;
        ram_bus_enable_n             = 1'b1;
        ram_write_enable_n           = 1'b1;
        ram_load_mar_reg_n           = 1'b1;
        program_counter_enable       = 1'b0;
        jump_n                       = 1'b1;
        program_counter_bus_enable_n = 1'b1;
        out_load_n                   = 1'b1;
        if (!reset && !halted_q) begin
            case (step_q)
                T0: begin
                    program_counter_bus_enable_n = 1'b0;
                    ram_load_mar_reg_n           = 1'b0;
                end
                T1: begin
                    ram_bus_enable_n       = 1'b0;
                    program_counter_enable = 1'b1;
                end
                T2: begin
                    case (ir_q[7:4])
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_bus_enable_n    = 1'b0;
                            ram_load_mar_reg_n = 1'b0;
                        end
                        OP_LDI: begin
                            ir_bus_enable_n = 1'b0;
                            reg_a_load_n    = 1'b0;
                        end
                        OP_JMP: begin
                            ir_bus_enable_n = 1'b0;
                            jump_n          = 1'b0;
                        end
                        OP_OUT: begin
                            reg_a_bus_enable_n = 1'b0;
                            out_load_n         = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (ir_q[7:4])
                        OP_LDA: begin
                            ram_bus_enable_n = 1'b0;
                            reg_a_load_n     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_bus_enable_n = 1'b0;
                            reg_b_load_n     = 1'b0;
                        end
                        OP_STA: begin
                            reg_a_bus_enable_n = 1'b0;
                            ram_write_enable_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if ((ir_q[7:4] == OP_ADD) || (ir_q[7:4] == OP_SUB)) begin
                        alu_enable_n = 1'b0;
                        reg_a_load_n = 1'b0;
                        alu_subtract = (ir_q[7:4] == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir_bus_out = {4'b0000, ir_q[3:0]};
    assign halted     = halted_q;
    assign step       = step_q;
    assign opcode     = ir_q[7:4];

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clocking: one clock `clk`; reset `reset` is asynchronous and active-high.
REQ-002 `clk`  in  1  system clock; all state changes on its rising edge.
REQ-003 `reset`  in  1  async active-high; clears all state.
REQ-004 `run`  in  1  1 = step counter advances; 0 = freeze state, all controls held.
REQ-005 `bus_in`  in  8  data bus value; IR captures it.
REQ-006 `ir_bus_out`  out  8  {4'b0, IR[3:0]}; valid only while `ir_bus_enable_n`=0.
REQ-007 `ir_bus_enable_n`  out  1  active-low; IR operand drives the bus.
REQ-008 `reg_a_load_n`, `reg_a_bus_enable_n`, `reg_b_load_n`  out  1 each  active-low register A/B controls.
REQ-009 `alu_enable_n`  out  1  active-low ALU bus enable. `alu_subtract`  out  1  active-high.
REQ-010 `ram_bus_enable_n`, `ram_write_enable_n`, `ram_load_mar_reg_n`  out  1 each  active-low RAM controls.
REQ-011 `program_counter_enable`  out  1  active-high increment. `jump_n`, `program_counter_bus_enable_n`  out  1 each  active-low.
REQ-012 `out_load_n`  out  1  active-low output-register load.
REQ-013 `halted`  out  1  high after HLT executes. `step`  out  3  current T-state, 0..4. `opcode`  out  4  IR[7:4].

Function
REQ-014 Control outputs: combinational decode of (step, IR, halted); inactive levels are 1 for `_n` outputs, 0 otherwise.
REQ-015 Step counter: 0→1→2→3→4→0 on each rising edge with run=1 and halted=0; fixed 5 steps per instruction, no early termination.
REQ-016 T0: `program_counter_bus_enable_n`=0, `ram_load_mar_reg_n`=0.
REQ-017 T1: `ram_bus_enable_n`=0, IR loads `bus_in` on the edge ending T1, `program_counter_enable`=1.
REQ-018 Opcodes (IR[7:4]) for T2/T3/T4; steps not listed are idle:
  - 0000 NOP: idle.
  - 0001 LDA: T2 IR-out + MAR-in; T3 RAM-out + A-in.
  - 0010 ADD: T2 IR-out + MAR-in; T3 RAM-out + B-in; T4 ALU-out + A-in.
  - 0011 SUB: as ADD, with `alu_subtract`=1 during T4.
  - 0100 STA: T2 IR-out + MAR-in; T3 A-out + `ram_write_enable_n`=0.
  - 0101 LDI: T2 IR-out + A-in.
  - 0110 JMP: T2 IR-out + `jump_n`=0.
  - 1110 OUT: T2 A-out + `out_load_n`=0.
  - 1111 HLT: T2 sets `halted`.
  - All other codes: NOP.
REQ-019 At most one bus-enable output is asserted in any step; this is an invariant.
REQ-020 HLT: `halted` register sets on the edge ending T2. `step` then holds at 3, and all controls stay inactive until reset. `run` has no effect once halted.
REQ-021 When run=0, step, IR and halted hold, and outputs remain decoded from the held state.

Reset
REQ-022 While reset=1: step=0, IR=8'h00, halted=0, and every control output is forced inactive, overriding the T0 decode.
REQ-023 Reset asserted mid-instruction aborts it immediately; the first step after release is T0.

Structure
REQ-024 A shared package holds the opcode constants (NOP..HLT), the T-state constants T0..T4, and the step width.
REQ-025 One sub-module, `step_counter`: mod-5 counter with enable, hold and async clear. Decode and the IR stay in `control_sequencer`.

Verification
REQ-026 Reset, run=1, 2 clocks, bus_in=8'h00 at T1 → T0 shows pc_bus_en_n=0 and mar_n=0; T1 shows ram_bus_en_n=0 and pc_enable=1; opcode=0 afterward.
REQ-027 bus_in=8'h2E at T1 (ADD 14) → T2 ir_bus_out=8'h0E with mar_n=0; T3 ram_bus_en_n=0 with reg_b_load_n=0; T4 alu_enable_n=0, reg_a_load_n=0, alu_subtract=0.
REQ-028 bus_in=8'h3E (SUB) → identical sequence to REQ-027 except alu_subtract=1 only in T4; JMP 8'h67 → T2 jump_n=0, ir_bus_out=8'h07.
REQ-029 bus_in=8'hF0 (HLT) → halted=1 after the T2 edge; step stays 3 for 10 further clocks; all controls inactive.
REQ-030 Reset pulsed during T3 of LDA, including asynchronously between edges → outputs go inactive immediately; after release step=0, IR=0.
REQ-031 run=0 held for 3 clocks during T2 of STA → step stays 2 and the T2 controls hold; resuming with run=1 gives T3 A-out + write.
